// File: rtl/hamming_sec_rd_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | hamming_sec_rd_ctrl: read controller with Hamming(12,8) SEC decode and    |
// | optional scrub-on-read write-back.                    Revision: 1.0       |
// +--------------------------------------------------------------------------+
module hamming_sec_rd_ctrl #(
  parameter int SCRUB_EN = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_req,
  input  logic [3:0]       rd_addr,
  output logic             rd_ready,
  output logic             rd_valid,
  output logic [7:0]       rd_data,
  output logic             err_corrected,
  output logic             err_uncorrectable,
  output logic [3:0]       mem_addr,
  input  logic [11:0]      mem_rdata,
  output logic             mem_wr_en,
  output logic [11:0]      mem_wdata,
  output logic [CNT_W-1:0] corr_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_CHECK = 2'd2,
    S_WB    = 2'd3
  } state_t;

  // Codeword bit i carries Hamming position i+1; mask k selects positions with index bit k set.
  localparam logic [11:0]      c_MASK_S0 = 12'h555;
  localparam logic [11:0]      c_MASK_S1 = 12'h666;
  localparam logic [11:0]      c_MASK_S2 = 12'h878;
  localparam logic [11:0]      c_MASK_S3 = 12'hF80;
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_addr;
  logic [11:0]       r_cw;
  logic [11:0]       r_cw_fix;
  logic [7:0]        r_rd_data;
  logic              r_rd_valid;
  logic              r_err_corr;
  logic              r_err_unc;
  logic [CNT_W-1:0]  r_corr_count;

  logic [3:0]        w_syn;
  logic              w_correctable;
  logic              w_uncorrectable;
  logic [11:0]       w_flip;
  logic [11:0]       w_cw_fix;
  logic [7:0]        w_data;

  assign w_syn = {^(r_cw & c_MASK_S3), ^(r_cw & c_MASK_S2),
                  ^(r_cw & c_MASK_S1), ^(r_cw & c_MASK_S0)};
  assign w_correctable   = (w_syn != 4'd0) && (w_syn <= 4'd12);
  assign w_uncorrectable = (w_syn >= 4'd13);
  assign w_flip          = w_correctable ? (12'd1 << (w_syn - 4'd1)) : 12'd0;
  assign w_cw_fix        = r_cw ^ w_flip;
  // Data bits live at positions 3,5,6,7,9,10,11,12 (uncorrectable words pass through raw).
  assign w_data          = {w_cw_fix[11:8], w_cw_fix[6:4], w_cw_fix[2]};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (rd_req) w_state_nxt = S_READ;
      S_READ:  w_state_nxt = S_CHECK;
      S_CHECK: w_state_nxt = ((SCRUB_EN != 0) && w_correctable) ? S_WB : S_IDLE;
      S_WB:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr       <= 4'd0;
      r_cw         <= 12'd0;
      r_cw_fix     <= 12'd0;
      r_rd_data    <= 8'd0;
      r_rd_valid   <= 1'b0;
      r_err_corr   <= 1'b0;
      r_err_unc    <= 1'b0;
      r_corr_count <= '0;
    end else begin
      r_rd_valid <= (r_state == S_CHECK);
      if ((r_state == S_IDLE) && rd_req) r_addr <= rd_addr;
      if (r_state == S_READ) r_cw <= mem_rdata;
      if (r_state == S_CHECK) begin
        r_rd_data  <= w_data;
        r_err_corr <= w_correctable;
        r_err_unc  <= w_uncorrectable;
        r_cw_fix   <= w_cw_fix;
        if (w_correctable && (r_corr_count != c_CNT_MAX))
          r_corr_count <= r_corr_count + CNT_W'(1);
      end
    end
  end

  // Write enable is decoded from state so an asynchronous reset kills it at once.
  assign rd_ready          = (r_state == S_IDLE);
  assign mem_wr_en         = (r_state == S_WB);
  assign mem_addr          = r_addr;
  assign mem_wdata         = r_cw_fix;
  assign rd_valid          = r_rd_valid;
  assign rd_data           = r_rd_data;
  assign err_corrected     = r_err_corr;
  assign err_uncorrectable = r_err_unc;
  assign corr_count        = r_corr_count;

endmodule
`default_nettype wire
